// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive controller and its surroundings
// (line, host configuration, receiver byte path, FIFO consumer).
interface uart_rx_ctrl_if;
  logic       RX_IN;
  logic       CFG_WR;
  logic       CFG_PAR_EN;
  logic       CFG_PAR_TYP;
  logic [4:0] CFG_PRESCALE;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [4:0] prescale;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       RD_EN;
  logic [7:0] RD_DATA;
  logic       EMPTY;
  logic       FULL;
  logic [4:0] COUNT;
  logic       OVERRUN;
  logic       CLR_OVR;
  logic       CFG_PENDING;
  logic       CFG_ERR;
  logic       QUIET;

  modport slave (
    input  RX_IN, CFG_WR, CFG_PAR_EN, CFG_PAR_TYP, CFG_PRESCALE,
           P_DATA, data_valid, RD_EN, CLR_OVR,
    output PAR_EN, PAR_TYP, prescale, RD_DATA, EMPTY, FULL, COUNT,
           OVERRUN, CFG_PENDING, CFG_ERR, QUIET
  );

  modport master (
    output RX_IN, CFG_WR, CFG_PAR_EN, CFG_PAR_TYP, CFG_PRESCALE,
           P_DATA, data_valid, RD_EN, CLR_OVR,
    input  PAR_EN, PAR_TYP, prescale, RD_DATA, EMPTY, FULL, COUNT,
           OVERRUN, CFG_PENDING, CFG_ERR, QUIET
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive control: line-quiet detector gating configuration updates,
// plus a first-word-fall-through byte FIFO with sticky overrun.
module uart_rx_ctrl #(
  parameter int DEPTH        = 4,
  parameter int IDLE_BITS    = 2,
  parameter int DEF_PRESCALE = 8,
  parameter bit DEF_PAR_EN   = 1'b1
) (
  input logic           CLK,
  input logic           RST,
  uart_rx_ctrl_if.slave bus
);
  localparam int         AW      = $clog2(DEPTH);
  localparam logic [3:0] IB      = 4'(IDLE_BITS);
  localparam logic [4:0] DEF_PS  = 5'(DEF_PRESCALE);
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  typedef enum logic {ACTIVE, QUIET} line_e;

  line_e      state, state_nxt;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       bit_wrap;

  assign bit_wrap = (edge_cnt == bus.prescale - 5'd1);

  always_ff @(posedge CLK) begin
    if (RST) state <= ACTIVE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!bus.RX_IN)                            state_nxt = ACTIVE;
    else if (state == ACTIVE && bit_cnt == IB) state_nxt = QUIET;
  end

  always_comb bus.QUIET = (state == QUIET);

  // Counters only run while qualifying a high stretch; QUIET holds them at 0
  // so any config applied there restarts timing from a clean count.
  always_ff @(posedge CLK) begin
    if (RST || !bus.RX_IN || state == QUIET || state_nxt == QUIET) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (bit_wrap) begin
      edge_cnt <= '0;
      bit_cnt  <= (bit_cnt == IB) ? bit_cnt : bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 5'd1;
    end
  end

  logic       cfg_ok;
  logic       sh_par_en, sh_par_typ;
  logic [4:0] sh_prescale;

  assign cfg_ok = bus.CFG_WR && (bus.CFG_PRESCALE >= 5'd4);

  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.PAR_EN      <= DEF_PAR_EN;
      bus.PAR_TYP     <= 1'b0;
      bus.prescale    <= DEF_PS;
      sh_par_en       <= DEF_PAR_EN;
      sh_par_typ      <= 1'b0;
      sh_prescale     <= DEF_PS;
      bus.CFG_PENDING <= 1'b0;
      bus.CFG_ERR     <= 1'b0;
    end else begin
      bus.CFG_ERR <= bus.CFG_WR && !cfg_ok;
      if (state == QUIET && cfg_ok) begin
        bus.PAR_EN      <= bus.CFG_PAR_EN;
        bus.PAR_TYP     <= bus.CFG_PAR_TYP;
        bus.prescale    <= bus.CFG_PRESCALE;
        bus.CFG_PENDING <= 1'b0;
      end else if (state == QUIET && bus.CFG_PENDING) begin
        bus.PAR_EN      <= sh_par_en;
        bus.PAR_TYP     <= sh_par_typ;
        bus.prescale    <= sh_prescale;
        bus.CFG_PENDING <= 1'b0;
      end else if (cfg_ok) begin
        sh_par_en       <= bus.CFG_PAR_EN;
        sh_par_typ      <= bus.CFG_PAR_TYP;
        sh_prescale     <= bus.CFG_PRESCALE;
        bus.CFG_PENDING <= 1'b1;
      end
    end
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    last_rd;
  logic          do_rd, do_wr, drop;
  logic [4:0]    count_nxt;

  // A full FIFO accepts a push when the same cycle pops, so no byte is lost.
  assign do_rd     = bus.RD_EN && !bus.EMPTY;
  assign do_wr     = bus.data_valid && (!bus.FULL || do_rd);
  assign drop      = bus.data_valid && bus.FULL && !do_rd;
  assign count_nxt = bus.COUNT + {4'd0, do_wr} - {4'd0, do_rd};

  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr] <= bus.P_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      last_rd     <= '0;
      bus.COUNT   <= '0;
      bus.EMPTY   <= 1'b1;
      bus.FULL    <= 1'b0;
      bus.OVERRUN <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) begin
        rd_ptr  <= rd_ptr + AW'(1);
        last_rd <= mem[rd_ptr];
      end
      bus.COUNT <= count_nxt;
      bus.EMPTY <= (count_nxt == 5'd0);
      bus.FULL  <= (count_nxt == DEPTH_C);
      if (drop)             bus.OVERRUN <= 1'b1;
      else if (bus.CLR_OVR) bus.OVERRUN <= 1'b0;
    end
  end

  // Stale storage must not leak out once drained; show the last popped byte.
  assign bus.RD_DATA = bus.EMPTY ? last_rd : mem[rd_ptr];
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed scenarios plus a randomized run, all scored against a
// cycle-level behavioural model of the controller kept in this bench.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 4;
  localparam int IB    = 2;
  localparam int DEFP  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_ctrl_if bus();

  uart_rx_ctrl #(.DEPTH(DEPTH), .IDLE_BITS(IB), .DEF_PRESCALE(DEFP), .DEF_PAR_EN(1'b1))
    dut (.CLK(clk), .RST(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit       m_par_en, m_typ, m_pend, m_err, m_quiet, m_ovr;
  int       m_p, m_run;
  bit       s_en, s_typ;
  int       s_p;
  bit [7:0] m_last;
  bit [7:0] q[$];

  task automatic model_step();
    bit ok, oq, full;
    if (rst) begin
      m_par_en = 1'b1; m_typ = 1'b0; m_p = DEFP;
      m_pend = 0; m_err = 0; m_quiet = 0; m_ovr = 0; m_run = 0; m_last = 8'h00;
      q.delete();
      return;
    end
    oq    = m_quiet;
    ok    = bus.CFG_WR && (bus.CFG_PRESCALE >= 5'd4);
    m_err = bus.CFG_WR && !ok;
    // Quiet after IB*prescale high cycles have been counted, seen one cycle later.
    if (!bus.RX_IN) begin
      m_run = 0; m_quiet = 0;
    end else begin
      if (m_run < 100000) m_run++;
      if (!oq && m_run >= IB * m_p + 1) m_quiet = 1;
    end
    if (oq && ok) begin
      m_par_en = bus.CFG_PAR_EN; m_typ = bus.CFG_PAR_TYP; m_p = int'(bus.CFG_PRESCALE); m_pend = 0;
    end else if (oq && m_pend) begin
      m_par_en = s_en; m_typ = s_typ; m_p = s_p; m_pend = 0;
    end else if (ok) begin
      s_en = bus.CFG_PAR_EN; s_typ = bus.CFG_PAR_TYP; s_p = int'(bus.CFG_PRESCALE); m_pend = 1;
    end
    full = (q.size() == DEPTH);
    if (bus.RD_EN && q.size() > 0) m_last = q.pop_front();
    if (bus.data_valid && full && !bus.RD_EN) m_ovr = 1;
    else begin
      if (bus.data_valid) q.push_back(bus.P_DATA);
      if (bus.CLR_OVR) m_ovr = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    bus.RX_IN = 0; bus.CFG_WR = 0; bus.CFG_PAR_EN = 0; bus.CFG_PAR_TYP = 0;
    bus.CFG_PRESCALE = 0; bus.P_DATA = 0; bus.data_valid = 0; bus.RD_EN = 0; bus.CLR_OVR = 0;
    rst = 1; tick(); tick(); rst = 0;
    n_cmp++;
    if ({bus.PAR_EN, bus.PAR_TYP, bus.prescale} !== {1'b1, 1'b0, 5'd8}) begin
      n_bad++; $display("FAIL reset_cfg got %b exp %b", {bus.PAR_EN, bus.PAR_TYP, bus.prescale}, {1'b1, 1'b0, 5'd8});
    end
    n_cmp++;
    if ({bus.EMPTY, bus.FULL, bus.COUNT, bus.RD_DATA} !== {1'b1, 1'b0, 5'd0, 8'h00}) begin
      n_bad++; $display("FAIL reset_fifo got %h exp %h", {bus.EMPTY, bus.FULL, bus.COUNT, bus.RD_DATA}, {1'b1, 1'b0, 5'd0, 8'h00});
    end
    n_cmp++;
    if ({bus.OVERRUN, bus.CFG_PENDING, bus.CFG_ERR, bus.QUIET} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags got %b exp 0000", {bus.OVERRUN, bus.CFG_PENDING, bus.CFG_ERR, bus.QUIET});
    end
  endtask

  task automatic test_quiet();
    bus.RX_IN = 1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      n_cmp++;
      if (bus.QUIET !== (i == 17)) begin
        n_bad++; $display("FAIL quiet_rise cycle %0d got %b exp %b", i, bus.QUIET, (i == 17));
      end
    end
  endtask

  task automatic test_cfg_pending();
    bus.RX_IN = 0; tick();
    bus.CFG_WR = 1; bus.CFG_PAR_EN = 0; bus.CFG_PAR_TYP = 1; bus.CFG_PRESCALE = 5'd16;
    tick();
    bus.CFG_WR = 0;
    n_cmp++;
    if ({bus.CFG_PENDING, bus.PAR_EN, bus.PAR_TYP, bus.prescale} !== {1'b1, 1'b1, 1'b0, 5'd8}) begin
      n_bad++; $display("FAIL pend_set got %b exp %b", {bus.CFG_PENDING, bus.PAR_EN, bus.PAR_TYP, bus.prescale}, {1'b1, 1'b1, 1'b0, 5'd8});
    end
    bus.RX_IN = 1;
    for (int i = 0; i < 17; i++) tick();
    n_cmp++;
    if ({bus.QUIET, bus.CFG_PENDING, bus.prescale} !== {1'b1, 1'b1, 5'd8}) begin
      n_bad++; $display("FAIL pend_hold_at_quiet got %b exp %b", {bus.QUIET, bus.CFG_PENDING, bus.prescale}, {1'b1, 1'b1, 5'd8});
    end
    tick();
    n_cmp++;
    if ({bus.CFG_PENDING, bus.PAR_EN, bus.PAR_TYP, bus.prescale} !== {1'b0, 1'b0, 1'b1, 5'd16}) begin
      n_bad++; $display("FAIL pend_apply got %b exp %b", {bus.CFG_PENDING, bus.PAR_EN, bus.PAR_TYP, bus.prescale}, {1'b0, 1'b0, 1'b1, 5'd16});
    end
  endtask

  task automatic test_cfg_err();
    int k;
    bus.RX_IN = 0; tick();
    bus.CFG_WR = 1; bus.CFG_PAR_EN = 1; bus.CFG_PAR_TYP = 0; bus.CFG_PRESCALE = 5'd3;
    tick(); bus.CFG_WR = 0;
    n_cmp++;
    if ({bus.CFG_ERR, bus.CFG_PENDING, bus.prescale} !== {1'b1, 1'b0, 5'd16}) begin
      n_bad++; $display("FAIL err_pulse got %b exp %b", {bus.CFG_ERR, bus.CFG_PENDING, bus.prescale}, {1'b1, 1'b0, 5'd16});
    end
    tick();
    n_cmp++;
    if (bus.CFG_ERR !== 1'b0) begin
      n_bad++; $display("FAIL err_one_cycle got %b exp 0", bus.CFG_ERR);
    end
    bus.CFG_WR = 1; bus.CFG_PAR_EN = 1; bus.CFG_PAR_TYP = 0; bus.CFG_PRESCALE = 5'd5; tick();
    bus.CFG_PAR_EN = 0; bus.CFG_PRESCALE = 5'd2; tick();
    bus.CFG_WR = 0;
    n_cmp++;
    if ({bus.CFG_ERR, bus.CFG_PENDING} !== 2'b11) begin
      n_bad++; $display("FAIL err_keeps_pending got %b exp 11", {bus.CFG_ERR, bus.CFG_PENDING});
    end
    bus.CFG_WR = 1; bus.CFG_PAR_EN = 1; bus.CFG_PAR_TYP = 1; bus.CFG_PRESCALE = 5'd6; tick();
    bus.CFG_WR = 0; bus.RX_IN = 1;
    k = 0;
    while (!bus.QUIET && k < 60) begin tick(); k++; end
    n_cmp++;
    if (k != 2 * 16 + 1) begin
      n_bad++; $display("FAIL quiet_at_p16 got %0d cycles exp %0d", k, 2 * 16 + 1);
    end
    tick();
    n_cmp++;
    if ({bus.CFG_PENDING, bus.PAR_EN, bus.PAR_TYP, bus.prescale} !== {1'b0, 1'b1, 1'b1, 5'd6}) begin
      n_bad++; $display("FAIL last_write_wins got %b exp %b", {bus.CFG_PENDING, bus.PAR_EN, bus.PAR_TYP, bus.prescale}, {1'b0, 1'b1, 1'b1, 5'd6});
    end
  endtask

  task automatic test_overrun();
    bit [7:0] v;
    for (int i = 0; i < 5; i++) begin
      bus.data_valid = 1; bus.P_DATA = 8'hA1 + 8'(i); tick();
    end
    bus.data_valid = 0;
    n_cmp++;
    if ({bus.FULL, bus.COUNT, bus.OVERRUN, bus.RD_DATA} !== {1'b1, 5'd4, 1'b1, 8'hA1}) begin
      n_bad++; $display("FAIL ovr_full got %h exp %h", {bus.FULL, bus.COUNT, bus.OVERRUN, bus.RD_DATA}, {1'b1, 5'd4, 1'b1, 8'hA1});
    end
    for (int i = 0; i < 4; i++) begin
      v = 8'hA1 + 8'(i);
      n_cmp++;
      if (bus.RD_DATA !== v) begin
        n_bad++; $display("FAIL ovr_pop%0d got %h exp %h", i, bus.RD_DATA, v);
      end
      bus.RD_EN = 1; tick(); bus.RD_EN = 0;
    end
    n_cmp++;
    if ({bus.EMPTY, bus.COUNT, bus.RD_DATA} !== {1'b1, 5'd0, 8'hA4}) begin
      n_bad++; $display("FAIL ovr_drained got %h exp %h", {bus.EMPTY, bus.COUNT, bus.RD_DATA}, {1'b1, 5'd0, 8'hA4});
    end
    bus.RD_EN = 1; tick(); bus.RD_EN = 0;
    n_cmp++;
    if ({bus.EMPTY, bus.COUNT, bus.RD_DATA} !== {1'b1, 5'd0, 8'hA4}) begin
      n_bad++; $display("FAIL empty_read_ignored got %h exp %h", {bus.EMPTY, bus.COUNT, bus.RD_DATA}, {1'b1, 5'd0, 8'hA4});
    end
    bus.CLR_OVR = 1; tick(); bus.CLR_OVR = 0;
    n_cmp++;
    if (bus.OVERRUN !== 1'b0) begin
      n_bad++; $display("FAIL ovr_clear got %b exp 0", bus.OVERRUN);
    end
  endtask

  task automatic test_full_rw();
    bit [7:0] b[5];
    for (int i = 0; i < 3; i++) begin bus.data_valid = 1; bus.P_DATA = 8'(i); tick(); end
    bus.data_valid = 0;
    for (int i = 0; i < 3; i++) begin bus.RD_EN = 1; tick(); end
    bus.RD_EN = 0;
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      bus.data_valid = 1; bus.P_DATA = b[i]; tick();
    end
    b[4] = 8'h5C;
    bus.P_DATA = 8'h5C; bus.RD_EN = 1; tick();
    bus.data_valid = 0; bus.RD_EN = 0;
    n_cmp++;
    if ({bus.FULL, bus.COUNT, bus.OVERRUN} !== {1'b1, 5'd4, 1'b0}) begin
      n_bad++; $display("FAIL full_rw got %b exp %b", {bus.FULL, bus.COUNT, bus.OVERRUN}, {1'b1, 5'd4, 1'b0});
    end
    for (int i = 1; i < 5; i++) begin
      n_cmp++;
      if (bus.RD_DATA !== b[i]) begin
        n_bad++; $display("FAIL wrap_order%0d got %h exp %h", i, bus.RD_DATA, b[i]);
      end
      bus.RD_EN = 1; tick(); bus.RD_EN = 0;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin bus.data_valid = 1; bus.P_DATA = 8'h30 + 8'(i); tick(); end
    bus.data_valid = 0; bus.RX_IN = 0; tick();
    bus.CFG_WR = 1; bus.CFG_PAR_EN = 0; bus.CFG_PAR_TYP = 0; bus.CFG_PRESCALE = 5'd9; tick();
    bus.CFG_WR = 0;
    n_cmp++;
    if ({bus.COUNT, bus.CFG_PENDING} !== {5'd3, 1'b1}) begin
      n_bad++; $display("FAIL pre_reset got %b exp %b", {bus.COUNT, bus.CFG_PENDING}, {5'd3, 1'b1});
    end
    bus.RX_IN = 1; rst = 1; tick(); rst = 0;
    n_cmp++;
    if ({bus.EMPTY, bus.COUNT, bus.CFG_PENDING, bus.QUIET, bus.RD_DATA} !== {1'b1, 5'd0, 1'b0, 1'b0, 8'h00}) begin
      n_bad++; $display("FAIL mid_reset_fifo got %h exp %h", {bus.EMPTY, bus.COUNT, bus.CFG_PENDING, bus.QUIET, bus.RD_DATA}, {1'b1, 5'd0, 1'b0, 1'b0, 8'h00});
    end
    n_cmp++;
    if ({bus.PAR_EN, bus.PAR_TYP, bus.prescale} !== {1'b1, 1'b0, 5'd8}) begin
      n_bad++; $display("FAIL mid_reset_cfg got %b exp %b", {bus.PAR_EN, bus.PAR_TYP, bus.prescale}, {1'b1, 1'b0, 5'd8});
    end
  endtask

  task automatic test_random();
    bit       hi_mode;
    bit [7:0] exp_rd;
    hi_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 3) hi_mode = !hi_mode;
      bus.RX_IN        = ($urandom_range(0, 99) < (hi_mode ? 99 : 40));
      bus.CFG_WR       = ($urandom_range(0, 99) < 5);
      bus.CFG_PAR_EN   = 1'($urandom);
      bus.CFG_PAR_TYP  = 1'($urandom);
      bus.CFG_PRESCALE = 5'($urandom_range(0, 12));
      bus.data_valid   = ($urandom_range(0, 99) < 35);
      bus.P_DATA       = 8'($urandom);
      bus.RD_EN        = ($urandom_range(0, 99) < 30);
      bus.CLR_OVR      = ($urandom_range(0, 99) < 5);
      rst              = ($urandom_range(0, 999) < 3);
      tick();
      exp_rd = (q.size() > 0) ? q[0] : m_last;
      n_cmp++;
      if ({bus.PAR_EN, bus.PAR_TYP, bus.prescale, bus.CFG_PENDING, bus.CFG_ERR, bus.QUIET} !==
          {m_par_en, m_typ, 5'(m_p), m_pend, m_err, m_quiet}) begin
        n_bad++; $display("FAIL rand_cfg cyc %0d got %b exp %b", c,
          {bus.PAR_EN, bus.PAR_TYP, bus.prescale, bus.CFG_PENDING, bus.CFG_ERR, bus.QUIET},
          {m_par_en, m_typ, 5'(m_p), m_pend, m_err, m_quiet});
      end
      n_cmp++;
      if ({bus.COUNT, bus.EMPTY, bus.FULL, bus.OVERRUN} !==
          {5'(q.size()), q.size() == 0, q.size() == DEPTH, m_ovr}) begin
        n_bad++; $display("FAIL rand_fifo cyc %0d got %b exp %b", c, {bus.COUNT, bus.EMPTY, bus.FULL, bus.OVERRUN},
          {5'(q.size()), q.size() == 0, q.size() == DEPTH, m_ovr});
      end
      n_cmp++;
      if (bus.RD_DATA !== exp_rd) begin
        n_bad++; $display("FAIL rand_rd cyc %0d got %h exp %h", c, bus.RD_DATA, exp_rd);
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_quiet();
    test_cfg_pending();
    test_cfg_err();
    test_overrun();
    test_full_rw();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
